// File: rtl/unary_add_1_4_7.sv
// ---------------------------------------------------------------------------
// unary_add_1_4_7
//
// Unary (thermometer) stream adder. In read mode the block counts the ones
// arriving on A and B into a saturating 7-bit accumulator. In write mode it
// plays the accumulated total back out as a unary stream on dout, one unit
// per cycle, until the accumulator is empty.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (clears CNT, dout, C)
//   A, B           unary operand streams, one bit per cycle
//   en             enable; when low, CNT and C hold and dout is 0
//   read_or_write  0 = read (accumulate A+B), 1 = write (emit CNT on dout)
//   dout           registered unary output stream
//   C              registered sticky overflow flag
// ---------------------------------------------------------------------------
module unary_add_1_4_7 (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic en,
  input  logic read_or_write,
  output logic dout,
  output logic C
);

  localparam int               CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  mode_e            mode;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             dout_next;
  logic             c_next;
  // One extra bit so that a sum past CNT_MAX is visible before saturation.
  logic [CNT_W:0]   sum;

  assign mode = mode_e'(read_or_write);
  assign sum  = {1'b0, cnt} + {{CNT_W{1'b0}}, A} + {{CNT_W{1'b0}}, B};

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_next  = cnt;
    dout_next = 1'b0;
    c_next    = C;

    if (en) begin
      unique case (mode)
        MODE_READ: begin
          if (sum > {1'b0, CNT_MAX}) begin
            cnt_next = CNT_MAX;
            c_next   = 1'b1;
          end else begin
            cnt_next = sum[CNT_W-1:0];
          end
        end
        MODE_WRITE: begin
          // An empty accumulator just emits zeros; it never wraps below 0.
          if (cnt != '0) begin
            dout_next = 1'b1;
            cnt_next  = cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
      C    <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      dout <= dout_next;
      C    <= c_next;
    end
  end

endmodule

// File: tb/tb_unary_add_1_4_7.sv
// ---------------------------------------------------------------------------
// tb_unary_add_1_4_7
//
// Self-checking bench for unary_add_1_4_7. A behavioural model tracks the
// accumulator as a plain integer and predicts dout and C; a compare process
// checks the DUT against it on every falling edge. Directed sequences pin the
// model to hand-computed values, then a randomized phase exercises mode
// switches, enable gaps, saturation and mid-cycle resets.
// ---------------------------------------------------------------------------
module tb_unary_add_1_4_7;

  logic clk           = 1'b0;
  logic rst_n         = 1'b0;
  logic A             = 1'b0;
  logic B             = 1'b0;
  logic en            = 1'b0;
  logic read_or_write = 1'b0;
  logic dout;
  logic C;

  int checks = 0;
  int errors = 0;

  unary_add_1_4_7 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .B             (B),
    .en            (en),
    .read_or_write (read_or_write),
    .dout          (dout),
    .C             (C)
  );

  always #5 clk = ~clk;

  // Behavioural model: the accumulator is an ordinary integer clamped at 127.
  int   m_cnt  = 0;
  logic m_dout = 1'b0;
  logic m_c    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_dout <= 1'b0;
      m_c    <= 1'b0;
    end else if (!en) begin
      m_dout <= 1'b0;
    end else if (!read_or_write) begin
      m_dout <= 1'b0;
      if (m_cnt + int'(A) + int'(B) > 127) begin
        m_cnt <= 127;
        m_c   <= 1'b1;
      end else begin
        m_cnt <= m_cnt + int'(A) + int'(B);
      end
    end else if (m_cnt > 0) begin
      m_dout <= 1'b1;
      m_cnt  <= m_cnt - 1;
    end else begin
      m_dout <= 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are registered, so the falling edge is a stable sampling point.
  always @(negedge clk) begin
    check("model_dout", int'(dout), int'(m_dout));
    check("model_C", int'(C), int'(m_c));
  end

  // One clock edge with the given inputs; returns dout just after the edge.
  task automatic cyc(input logic a, input logic b, input logic e,
                     input logic rw, output logic d);
    @(negedge clk);
    A = a; B = b; en = e; read_or_write = rw;
    @(posedge clk);
    #1 d = dout;
  endtask

  // n enabled write edges; counts the ones seen on dout.
  task automatic drain(input int n, output int ones, output logic last);
    logic d;
    ones = 0;
    last = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, d);
      ones += int'(d);
      last = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic       d;
    logic       last;
    logic [5:0] seq;
    logic [4:0] sa;
    logic [4:0] sb;
    int         ones;
    int         first_c;
    int         or_d;

    // Reset state.
    #3;
    check("reset_dout", int'(dout), 0);
    check("reset_C", int'(C), 0);
    do_reset();

    // 19 edges of A=B=1 -> 38.
    for (int i = 0; i < 19; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, d);
    check("acc38_dout", int'(d), 0);
    check("acc38_C", int'(C), 0);
    drain(20, ones, last);
    check("write20_ones", ones, 20);
    check("write20_C", int'(C), 0);
    drain(20, ones, last);
    check("write_rest_ones", ones, 18);
    check("write_rest_last", int'(last), 0);

    // Mixed streams sum to 4, then played back over 6 edges.
    sa = 5'b11100;
    sb = 5'b10000;
    for (int i = 4; i >= 0; i--) cyc(sa[i], sb[i], 1'b1, 1'b0, d);
    for (int i = 5; i >= 0; i--) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, d);
      seq[i] = d;
    end
    check("seq4_pattern", int'(seq), int'(6'b111100));

    // Sum landing exactly on 127 is not an overflow; one more unit is.
    for (int i = 0; i < 63; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, d);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, d);
    check("exact127_C", int'(C), 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, d);
    check("over127_C", int'(C), 1);
    drain(130, ones, last);
    check("exact127_ones", ones, 127);
    check("sticky_after_drain_C", int'(C), 1);
    do_reset();

    // 70 edges of A=B=1: overflow first seen on edge 64.
    first_c = 0;
    for (int i = 1; i <= 70; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, d);
      if (C && first_c == 0) first_c = i;
    end
    check("sat_first_C_edge", first_c, 64);
    check("sat_C", int'(C), 1);

    // Disabled write: no output, accumulator untouched.
    or_d = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
      or_d |= int'(d);
    end
    check("en0_dout", or_d, 0);
    drain(10, ones, last);
    check("en0_then_write_ones", ones, 10);

    // Reset between edges during emission takes effect immediately.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_C", int'(C), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain(3, ones, last);
    check("after_rst_ones", ones, 0);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) read_or_write = ~read_or_write;
      if ($urandom_range(0, 799) == 0) begin
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) != 0), read_or_write, d);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_add_1_4_7.md
UNARY_ADD_1_4_7 -- requirements
Module: unary_add_1_4_7

Interface
REQ-001 The module SHALL have a single clock and an asynchronous active-low reset, named as below.
REQ-002 clk  input  1  rising-edge clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 A  input  1  unary (thermometer) operand stream, one bit per cycle.
REQ-005 B  input  1  unary (thermometer) operand stream, one bit per cycle.
REQ-006 en  input  1  enable; when 0, the accumulator and C hold.
REQ-007 read_or_write  input  1  mode select: 0 = read (accumulate A+B), 1 = write (emit the sum as a unary stream).
REQ-008 dout  output  1  registered unary output stream of the accumulated sum.
REQ-009 C  output  1  registered sticky overflow flag.

Function
REQ-010 The block SHALL hold a 7-bit accumulator CNT, range 0..127.
REQ-011 Read, en=1: each rising edge SHALL set CNT <= CNT + A + B, adding 0, 1 or 2 per cycle.
REQ-012 Read, en=1: dout SHALL be registered 0.
REQ-013 Read saturation: if CNT + A + B > 127, CNT SHALL become 127 and C SHALL be set to 1 on that edge.
REQ-014 Write, en=1, CNT>0: each rising edge SHALL set dout <= 1 and CNT <= CNT-1.
REQ-015 Write, en=1, CNT=0: dout SHALL be registered 0 and CNT SHALL stay 0, with no underflow and no effect on C.
REQ-016 Consequence of REQ-014: a write phase starting with CNT=N SHALL emit exactly N consecutive dout=1 cycles, then dout=0.
REQ-017 en=0 in either mode: CNT and C SHALL hold, and dout SHALL be registered 0.
REQ-018 read_or_write SHALL be sampled each edge; a mode change takes effect on the next rising edge.
REQ-019 Mode changes SHALL not clear CNT.
REQ-020 After a partial write, returning to read SHALL resume accumulation from the remaining CNT.
REQ-021 C is sticky: once set, it SHALL stay 1 until reset; dout is unaffected by C.
REQ-022 Latency: an input pair sampled at edge k SHALL be reflected in CNT after edge k.
REQ-023 dout SHALL change only on rising edges (registered output, no combinational path from inputs).

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force CNT=0, dout=0, C=0.
REQ-025 Reset asserted mid-accumulation or mid-emission SHALL abort the operation.
REQ-026 After rst_n rises, the first rising edge SHALL operate normally.

Verification
REQ-027 Reset, then en=1, read, A=B=1 for 19 edges -> CNT=38, dout=0, C=0.
REQ-028 Then read_or_write=1 for 20 edges -> dout=1 on all 20 edges, CNT=18, C=0.
REQ-029 Continue write 20 more edges -> dout=1 for 18 edges then 0 for 2, CNT=0.
REQ-030 Read stream A=1,1,1,0,0 and B=1,0,0,0,0 -> CNT=4.
REQ-031 Then write for 6 edges -> dout = 1,1,1,1,0,0.
REQ-032 Read with A=B=1 for 70 edges -> CNT=127 and C=1 from edge 64 onward; CNT stays 127 through edge 70.
REQ-033 Write with en=0 for 5 edges -> dout=0 and CNT unchanged.
REQ-034 Assert rst_n=0 between clock edges during emission -> dout=0, C=0, CNT=0 immediately.
